// File: rtl/fact_dispatch.sv
// fact_dispatch: queues factorial requests and dispatches them, one at a time, to an external engine.
//   clk, reset                         : clock, asynchronous active-high reset
//   req_valid/req_ready/req_n/req_tag  : request handshake, operand and request id
//   rsp_valid/rsp_ready/rsp_data/
//   rsp_tag/rsp_ovf                    : response handshake, factorial, id, overflow flag
//   eng_start/eng_n/eng_done/eng_result: engine command and completion
//   busy                               : FSM not idle or requests still queued
module fact_dispatch #(
   parameter int DEPTH = 4,
   parameter int NMAX  = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [7:0]  req_n,
   input  logic [3:0]  req_tag,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic [3:0]  rsp_tag,
   output logic        rsp_ovf,
   output logic        eng_start,
   output logic [7:0]  eng_n,
   input  logic        eng_done,
   input  logic [15:0] eng_result,
   output logic        busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = DEPTH[AW:0];
   localparam logic [7:0] NMAX8 = NMAX[7:0];
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESPOND} state_t;
   state_t        state_q, state_d;
   logic [11:0]   mem_q [DEPTH];
   logic [11:0]   mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [15:0]   rsp_data_q, rsp_data_d;
   logic [3:0]    rsp_tag_q, rsp_tag_d;
   logic          rsp_ovf_q, rsp_ovf_d;
   logic [7:0]    eng_n_q, eng_n_d;
   logic          push, pop;
   logic [11:0]   head;
   always_comb begin
      push = req_valid && req_ready;
      pop = (state_q == IDLE) && (count_q != '0);
      head = mem_q[rd_ptr_q];
      mem_d = mem_q;
      if (push) mem_d[wr_ptr_q] = {req_n, req_tag};
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      state_d = state_q;
      rsp_data_d = rsp_data_q;
      rsp_tag_d = rsp_tag_q;
      rsp_ovf_d = rsp_ovf_q;
      eng_n_d = eng_n_q;
      case (state_q)
         IDLE: if (pop) begin
            rsp_tag_d = head[3:0];
            eng_n_d = head[11:4];
            if (head[11:4] <= 8'd1) begin
               rsp_data_d = 16'd1;
               rsp_ovf_d = 1'b0;
               state_d = RESPOND;
            end else if (head[11:4] > NMAX8) begin
               rsp_data_d = 16'd0;
               rsp_ovf_d = 1'b1;
               state_d = RESPOND;
            end else begin
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: state_d = eng_done ? CAPTURE : WAIT;
         // eng_result is only guaranteed the cycle after eng_done, hence the extra state
         CAPTURE: begin
            rsp_data_d = eng_result;
            rsp_ovf_d = 1'b0;
            state_d = RESPOND;
         end
         RESPOND: state_d = rsp_ready ? IDLE : RESPOND;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         mem_q <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
         rsp_data_q <= '0;
         rsp_tag_q <= '0;
         rsp_ovf_q <= 1'b0;
         eng_n_q <= '0;
      end else begin
         state_q <= state_d;
         mem_q <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         rsp_data_q <= rsp_data_d;
         rsp_tag_q <= rsp_tag_d;
         rsp_ovf_q <= rsp_ovf_d;
         eng_n_q <= eng_n_d;
      end
   end
   assign req_ready = count_q != FULL;
   assign rsp_valid = state_q == RESPOND;
   assign rsp_data = rsp_data_q;
   assign rsp_tag = rsp_tag_q;
   assign rsp_ovf = rsp_ovf_q;
   assign eng_start = state_q == ISSUE;
   assign eng_n = eng_n_q;
   assign busy = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_fact_dispatch.sv
// tb_fact_dispatch: directed bench for fact_dispatch with a behavioural factorial engine.
module tb_fact_dispatch;
   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [7:0]  req_n;
   logic [3:0]  req_tag;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_data;
   logic [3:0]  rsp_tag;
   logic        rsp_ovf;
   logic        eng_start;
   logic [7:0]  eng_n;
   logic        eng_done;
   logic [15:0] eng_result;
   logic        busy;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cyc = 0;
   int start_cnt = 0;
   logic eng_hold, spur_done, eng_done_m;
   logic [15:0] eng_result_m;
   logic [7:0] n_cur;
   logic [20:0] q[$];

   fact_dispatch #(.DEPTH(4), .NMAX(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ovf(rsp_ovf),
      .eng_start(eng_start), .eng_n(eng_n), .eng_done(eng_done), .eng_result(eng_result),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rsp_valid && rsp_ready) q.push_back({rsp_data, rsp_tag, rsp_ovf});
      if (eng_start) start_cnt <= start_cnt + 1;
   end

   function automatic logic [15:0] fact(input logic [7:0] n);
      logic [15:0] r;
      r = 16'd1;
      for (int i = 2; i <= int'(n); i++) r = r * 16'(i);
      return r;
   endfunction

   assign eng_done = eng_done_m | spur_done;
   assign eng_result = spur_done ? 16'hBEEF : eng_result_m;

   // engine: done one cycle after start, result garbage during the done cycle
   initial begin
      eng_done_m = 1'b0;
      eng_result_m = 16'h0;
      forever begin
         @(posedge clk); #1;
         if (eng_start && !eng_hold) begin
            n_cur = eng_n;
            @(posedge clk); #1;
            eng_done_m = 1'b1;
            eng_result_m = 16'hDEAD;
            done_cyc = cyc;
            @(posedge clk); #1;
            eng_done_m = 1'b0;
            eng_result_m = fact(n_cur);
         end
      end
   end

   task tick;
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [7:0] n, input logic [3:0] t);
      int k = 0;
      req_valid = 1'b1;
      req_n = n;
      req_tag = t;
      while (!req_ready && k < 200) begin tick(); k++; end
      if (!req_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout tag %0d ready got 0 want 1", t);
      end
      tick();
      req_valid = 1'b0;
   endtask

   task automatic wait_q(input int n);
      int k = 0;
      while (q.size() < n && k < 200) begin tick(); k++; end
      if (q.size() < n) begin
         checks++; errors++;
         $display("FAIL wait_rsp got %0d responses want %0d", q.size(), n);
      end
   endtask

   task automatic test_reset;
      repeat (3) tick();
      checks++;
      if ({rsp_valid, rsp_data, rsp_tag, rsp_ovf, eng_start, eng_n, busy, req_ready} !==
          {1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_state got %h want %h",
                  {rsp_valid, rsp_data, rsp_tag, rsp_ovf, eng_start, eng_n, busy, req_ready}, 33'h1);
      end
      reset = 1'b0;
      checks++;
      if ({busy, req_ready, rsp_valid} !== 3'b010) begin
         errors++;
         $display("FAIL reset_release got %b want 010", {busy, req_ready, rsp_valid});
      end
   endtask

   task automatic test_single;
      int s = start_cnt;
      int k = 0;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_n = 8'd5; req_tag = 4'd3;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL first_ready got %b want 1", req_ready); end
      tick();
      req_valid = 1'b0;
      checks++;
      if ({busy, eng_start} !== 2'b10) begin errors++; $display("FAIL first_accept got %b want 10", {busy, eng_start}); end
      tick();
      checks++;
      if ({eng_start, eng_n} !== {1'b1, 8'd5}) begin
         errors++; $display("FAIL issue got %h want %h", {eng_start, eng_n}, {1'b1, 8'd5});
      end
      tick();
      checks++;
      if ({eng_start, eng_n} !== {1'b0, 8'd5}) begin
         errors++; $display("FAIL start_one_cycle got %h want %h", {eng_start, eng_n}, {1'b0, 8'd5});
      end
      while (!rsp_valid && k < 50) begin tick(); k++; end
      checks++;
      if (cyc - done_cyc !== 2) begin errors++; $display("FAIL engine_latency got %0d want 2", cyc - done_cyc); end
      checks++;
      if ({rsp_valid, rsp_data, rsp_tag, rsp_ovf} !== {1'b1, 16'd120, 4'd3, 1'b0}) begin
         errors++; $display("FAIL rsp_5 got %h want %h", {rsp_valid, rsp_data, rsp_tag, rsp_ovf}, {1'b1, 16'd120, 4'd3, 1'b0});
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_drop got %b want 0", rsp_valid); end
      checks++;
      if (start_cnt - s !== 1) begin errors++; $display("FAIL start_count_5 got %0d want 1", start_cnt - s); end
   endtask

   task automatic test_local;
      int s = start_cnt;
      q.delete();
      req_valid = 1'b1; req_n = 8'd0; req_tag = 4'd1;
      tick();
      req_n = 8'd1; req_tag = 4'd2;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL local_early got %b want 0", rsp_valid); end
      tick();
      req_valid = 1'b0;
      checks++;
      if ({rsp_valid, rsp_data, rsp_tag, rsp_ovf} !== {1'b1, 16'd1, 4'd1, 1'b0}) begin
         errors++; $display("FAIL local_latency got %h want %h", {rsp_valid, rsp_data, rsp_tag, rsp_ovf}, {1'b1, 16'd1, 4'd1, 1'b0});
      end
      wait_q(2);
      checks++;
      if ({q[0], q[1]} !== {16'd1, 4'd1, 1'b0, 16'd1, 4'd2, 1'b0}) begin
         errors++; $display("FAIL local_order got %h %h want %h %h", q[0], q[1], {16'd1, 4'd1, 1'b0}, {16'd1, 4'd2, 1'b0});
      end
      checks++;
      if (start_cnt !== s) begin errors++; $display("FAIL local_no_start got %0d want %0d", start_cnt, s); end
   endtask

   task automatic test_bounds;
      int s = start_cnt;
      q.delete();
      send(8'd8, 4'd4);
      send(8'd9, 4'd5);
      send(8'd255, 4'd6);
      wait_q(3);
      checks++;
      if (q[0] !== {16'd40320, 4'd4, 1'b0}) begin errors++; $display("FAIL n8 got %h want %h", q[0], {16'd40320, 4'd4, 1'b0}); end
      checks++;
      if (q[1] !== {16'd0, 4'd5, 1'b1}) begin errors++; $display("FAIL n9 got %h want %h", q[1], {16'd0, 4'd5, 1'b1}); end
      checks++;
      if (q[2] !== {16'd0, 4'd6, 1'b1}) begin errors++; $display("FAIL n255 got %h want %h", q[2], {16'd0, 4'd6, 1'b1}); end
      checks++;
      if (start_cnt - s !== 1) begin errors++; $display("FAIL bounds_starts got %0d want 1", start_cnt - s); end
   endtask

   task automatic test_back_to_back;
      rsp_ready = 1'b0;
      q.delete();
      for (int t = 0; t < 5; t++) send(8'd2, 4'(t));
      req_valid = 1'b1; req_n = 8'd2; req_tag = 4'd5;
      repeat (10) tick();
      checks++;
      if ({req_ready, rsp_valid, rsp_data, rsp_tag, busy} !== {1'b0, 1'b1, 16'd2, 4'd0, 1'b1}) begin
         errors++; $display("FAIL full_stall got %h want %h", {req_ready, rsp_valid, rsp_data, rsp_tag, busy}, {1'b0, 1'b1, 16'd2, 4'd0, 1'b1});
      end
      rsp_ready = 1'b1;
      tick();
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_before_pop got %b want 0", req_ready); end
      tick();
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_pop got %b want 1", req_ready); end
      tick();
      req_valid = 1'b0;
      wait_q(6);
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (q[i] !== {16'd2, 4'(i), 1'b0}) begin
            errors++; $display("FAIL drain_%0d got %h want %h", i, q[i], {16'd2, 4'(i), 1'b0});
         end
      end
   endtask

   task automatic test_reset_mid;
      int k = 0;
      q.delete();
      rsp_ready = 1'b1;
      eng_hold = 1'b1;
      send(8'd7, 4'd9);
      while (!eng_start && k < 20) begin tick(); k++; end
      tick(); tick();
      reset = 1'b1;
      #1;
      checks++;
      if ({rsp_valid, rsp_data, rsp_tag, rsp_ovf, eng_start, eng_n, busy, req_ready} !==
          {1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 8'h0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL async_reset got %h want %h",
                  {rsp_valid, rsp_data, rsp_tag, rsp_ovf, eng_start, eng_n, busy, req_ready}, 33'h1);
      end
      tick(); tick();
      reset = 1'b0;
      eng_hold = 1'b0;
      repeat (6) tick();
      checks++;
      if ({q.size() == 0, busy, rsp_valid} !== 3'b100) begin
         errors++; $display("FAIL reset_discard got %b want 100", {q.size() == 0, busy, rsp_valid});
      end
      send(8'd4, 4'd10);
      wait_q(1);
      checks++;
      if (q[0] !== {16'd24, 4'd10, 1'b0}) begin errors++; $display("FAIL after_reset got %h want %h", q[0], {16'd24, 4'd10, 1'b0}); end
   endtask

   task automatic test_spurious;
      q.delete();
      rsp_ready = 1'b1;
      tick();
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      tick();
      checks++;
      if ({busy, rsp_valid, eng_start, rsp_data} !== {3'b000, 16'd24}) begin
         errors++; $display("FAIL spur_idle got %h want %h", {busy, rsp_valid, eng_start, rsp_data}, {3'b000, 16'd24});
      end
      rsp_ready = 1'b0;
      send(8'd0, 4'd11);
      tick();
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      tick();
      checks++;
      if ({rsp_valid, rsp_data, rsp_tag, rsp_ovf} !== {1'b1, 16'd1, 4'd11, 1'b0}) begin
         errors++; $display("FAIL spur_respond got %h want %h", {rsp_valid, rsp_data, rsp_tag, rsp_ovf}, {1'b1, 16'd1, 4'd11, 1'b0});
      end
      rsp_ready = 1'b1;
      wait_q(1);
      tick();
      checks++;
      if ({q.size() == 1, busy} !== 2'b10) begin errors++; $display("FAIL spur_finish got %b want 10", {q.size() == 1, busy}); end
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_n = 8'd0; req_tag = 4'd0;
      rsp_ready = 1'b1;
      eng_hold = 1'b0;
      spur_done = 1'b0;
      test_reset();
      test_single();
      test_local();
      test_bounds();
      test_back_to_back();
      test_reset_mid();
      test_spurious();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
